// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: button debounce, Idle/Run/Pause/Lap FSM and count-tick divider.
// All outputs are registered and change on the same edge as the state register.
module stopwatch_ctrl #(
  parameter int CLK_DIV         = 1200000,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter bit STOP_AT_MAX     = 1'b1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       btn_clear,
  input  logic       btn_start,
  input  logic       btn_stop,
  input  logic       btn_lap,
  input  logic       count_at_max,
  output logic       count_en,
  output logic       count_clr,
  output logic       lap_latch,
  output logic       lap_active,
  output logic [1:0] state,
  output logic       running
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_RUN   = 2'b01,
    S_PAUSE = 2'b10,
    S_LAP   = 2'b11
  } state_t;

  state_t st, st_n;

  // Button bit order: 0 clear, 1 stop, 2 start, 3 lap
  logic [3:0]    btn_raw, sync1, sync2, deb, deb_d, press;
  logic [CW-1:0] db_cnt [4];

  assign btn_raw = {btn_lap, btn_start, btn_stop, btn_clear};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_d <= '0;
      press <= '0;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      deb_d <= deb;
      press <= deb & ~deb_d;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          deb[i]    <= ~deb[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CW'(1);
        end
      end
    end
  end

  // Fixed priority: clear > stop > start > lap; only the winner can act
  logic w_clr, w_stop, w_start, w_lap;
  assign w_clr   = press[0];
  assign w_stop  = press[1] & ~press[0];
  assign w_start = press[2] & ~|press[1:0];
  assign w_lap   = press[3] & ~|press[2:0];

  logic [DW-1:0] div, div_n;
  logic          run_like, tick, max_stop;
  logic          en_n, clr_n, latch_n;

  assign run_like = (st == S_RUN) || (st == S_LAP);
  assign tick     = run_like && (div == DIV_LAST);
  assign max_stop = tick && count_at_max && STOP_AT_MAX;

  always_comb begin
    st_n    = st;
    clr_n   = 1'b0;
    latch_n = 1'b0;
    case (st)
      S_IDLE: begin
        if (w_clr)        clr_n = 1'b1;
        else if (w_start) st_n  = S_RUN;
      end
      S_RUN: begin
        if (w_clr) begin
          st_n  = S_IDLE;
          clr_n = 1'b1;
        end else if (w_stop) begin
          st_n = S_PAUSE;
        end else if (w_lap) begin
          st_n    = S_LAP;
          latch_n = 1'b1;
        end
      end
      S_LAP: begin
        if (w_clr) begin
          st_n  = S_IDLE;
          clr_n = 1'b1;
        end else if (w_stop) begin
          st_n = S_PAUSE;
        end else if (w_lap) begin
          st_n = S_RUN;
        end
      end
      default: begin
        if (w_clr) begin
          st_n  = S_IDLE;
          clr_n = 1'b1;
        end else if (w_start) begin
          st_n = S_RUN;
        end
      end
    endcase
    // A button transition takes precedence over the auto-pause at max
    if ((st_n == st) && max_stop) st_n = S_PAUSE;
    en_n = tick && !max_stop && (st_n != S_IDLE);
    if (st_n == S_IDLE)  div_n = '0;
    else if (run_like)   div_n = tick ? '0 : div + DW'(1);
    else                 div_n = div;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      st         <= S_IDLE;
      div        <= '0;
      count_en   <= 1'b0;
      count_clr  <= 1'b0;
      lap_latch  <= 1'b0;
      lap_active <= 1'b0;
      running    <= 1'b0;
    end else begin
      st         <= st_n;
      div        <= div_n;
      count_en   <= en_n;
      count_clr  <= clr_n;
      lap_latch  <= latch_n;
      lap_active <= (st_n == S_LAP);
      running    <= (st_n == S_RUN) || (st_n == S_LAP);
    end
  end

  assign state = st;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with CLK_DIV=10, DEBOUNCE_CYCLES=4; a second instance has STOP_AT_MAX=0.
// Expected count_en cycles go into exp_q as stimulus is driven and are matched against observed pulses.
module tb_stopwatch_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       btn_clear = 1'b0, btn_start = 1'b0, btn_stop = 1'b0, btn_lap = 1'b0;
  logic       count_at_max = 1'b0;
  logic       count_en, count_clr, lap_latch, lap_active, running;
  logic [1:0] state;
  logic       count_en1, count_clr1, lap_latch1, lap_active1, running1;
  logic [1:0] state1;

  stopwatch_ctrl #(.CLK_DIV(10), .DEBOUNCE_CYCLES(4), .STOP_AT_MAX(1'b1)) dut (
    .CLK(CLK), .RST(RST), .btn_clear(btn_clear), .btn_start(btn_start),
    .btn_stop(btn_stop), .btn_lap(btn_lap), .count_at_max(count_at_max),
    .count_en(count_en), .count_clr(count_clr), .lap_latch(lap_latch),
    .lap_active(lap_active), .state(state), .running(running)
  );

  stopwatch_ctrl #(.CLK_DIV(10), .DEBOUNCE_CYCLES(4), .STOP_AT_MAX(1'b0)) dut_wrap (
    .CLK(CLK), .RST(RST), .btn_clear(btn_clear), .btn_start(btn_start),
    .btn_stop(btn_stop), .btn_lap(btn_lap), .count_at_max(count_at_max),
    .count_en(count_en1), .count_clr(count_clr1), .lap_latch(lap_latch1),
    .lap_active(lap_active1), .state(state1), .running(running1)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int total = 0, passes = 0;
  int clr_cnt = 0, latch_cnt = 0, both_cnt = 0;
  int base = 0;
  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];

  // driver: advance n cycles, sampling outputs on the falling edge
  task automatic step(input int n);
    repeat (n) begin
      @(negedge CLK);
      if (!RST) begin
        if (count_en) obs_q.push_back(32'(cyc));
        if (count_clr) clr_cnt++;
        if (lap_latch) latch_cnt++;
        if (count_en && count_clr) both_cnt++;
      end
    end
  endtask

  task automatic push_ticks(input int a, input int b);
    for (int k = a; k <= b; k++)
      if (k > base && ((k - base) % 10) == 0) exp_q.push_back(32'(k));
  endtask

  task automatic test_reset();
    RST = 1'b1;
    step(3);
    total++;
    if ({state, count_en, count_clr, lap_latch, lap_active, running} !== 7'd0)
      $display("FAIL reset_outputs: got %b, required 0000000",
               {state, count_en, count_clr, lap_latch, lap_active, running});
    else passes++;
    total++;
    if ({state1, count_en1, count_clr1, lap_latch1, lap_active1, running1} !== 7'd0)
      $display("FAIL reset_outputs_wrap: got %b, required 0000000",
               {state1, count_en1, count_clr1, lap_latch1, lap_active1, running1});
    else passes++;
    RST = 1'b0;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_start();
    int c, a;
    logic [31:0] e, o;
    obs_q.delete();
    c = cyc;
    a = cyc + 1;
    btn_start = 1'b1;
    step(7);
    total++;
    if (state !== 2'b00) $display("FAIL start_early: state %b, required 00", state);
    else passes++;
    step(1);
    total++;
    if (state !== 2'b01 || running !== 1'b1 || cyc != c + 8)
      $display("FAIL start_latency: state %b running %b at +%0d, required 01 1 at +8", state, running, cyc - c);
    else passes++;
    base = cyc;
    step(2);
    btn_start = 1'b0;
    step(base + 30 - cyc);
    push_ticks(a, cyc);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hffffffff;
      total++;
      if (o !== e) $display("FAIL start_tick: count_en at cycle %0d, required %0d", o, e);
      else passes++;
    end
    total++;
    if (obs_q.size() != 0) $display("FAIL start_extra_tick: %0d extra, required 0", obs_q.size());
    else passes++;
  endtask

  task automatic test_glitch();
    int a;
    logic [31:0] e, o;
    obs_q.delete();
    a = cyc + 1;
    btn_stop = 1'b1;
    step(2);
    btn_stop = 1'b0;
    step(20);
    push_ticks(a, cyc);
    total++;
    if (state !== 2'b01) $display("FAIL glitch_state: state %b, required 01", state);
    else passes++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hffffffff;
      total++;
      if (o !== e) $display("FAIL glitch_tick: count_en at cycle %0d, required %0d", o, e);
      else passes++;
    end
    total++;
    if (obs_q.size() != 0) $display("FAIL glitch_extra_tick: %0d extra, required 0", obs_q.size());
    else passes++;
  endtask

  task automatic test_pause();
    int a, c, p, r;
    logic [31:0] e, o;
    obs_q.delete();
    a = cyc + 1;
    // stop lands on the edge leaving the divider at 4
    while (((cyc + 8 - base) % 10) != 4) step(1);
    c = cyc;
    btn_stop = 1'b1;
    step(6);
    btn_stop = 1'b0;
    step(c + 8 - cyc);
    p = cyc;
    total++;
    if (state !== 2'b10 || running !== 1'b0)
      $display("FAIL pause_enter: state %b running %b, required 10 0", state, running);
    else passes++;
    push_ticks(a, p);
    step(50);
    btn_start = 1'b1;
    step(6);
    btn_start = 1'b0;
    step(1);
    total++;
    if (state !== 2'b10) $display("FAIL pause_hold: state %b, required 10", state);
    else passes++;
    step(1);
    r = cyc;
    total++;
    if (state !== 2'b01) $display("FAIL pause_resume: state %b, required 01", state);
    else passes++;
    step(16);
    exp_q.push_back(32'(r + 6));
    exp_q.push_back(32'(r + 16));
    base = r - 4;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hffffffff;
      total++;
      if (o !== e) $display("FAIL pause_tick: count_en at cycle %0d, required %0d", o, e);
      else passes++;
    end
    total++;
    if (obs_q.size() != 0) $display("FAIL pause_extra_tick: %0d extra, required 0", obs_q.size());
    else passes++;
  endtask

  task automatic test_lap();
    int a, l0;
    logic [31:0] e, o;
    obs_q.delete();
    a = cyc + 1;
    l0 = latch_cnt;
    btn_lap = 1'b1;
    step(6);
    btn_lap = 1'b0;
    step(2);
    total++;
    if (state !== 2'b11 || lap_active !== 1'b1 || lap_latch !== 1'b1 || running !== 1'b1)
      $display("FAIL lap_enter: state %b active %b latch %b running %b, required 11 1 1 1",
               state, lap_active, lap_latch, running);
    else passes++;
    step(20);
    total++;
    if (latch_cnt != l0 + 1) $display("FAIL lap_latch_single: %0d pulses, required 1", latch_cnt - l0);
    else passes++;
    btn_lap = 1'b1;
    step(6);
    btn_lap = 1'b0;
    step(2);
    total++;
    if (state !== 2'b01 || lap_active !== 1'b0)
      $display("FAIL lap_exit: state %b active %b, required 01 0", state, lap_active);
    else passes++;
    step(5);
    total++;
    if (latch_cnt != l0 + 1) $display("FAIL lap_exit_latch: %0d pulses, required 1", latch_cnt - l0);
    else passes++;
    push_ticks(a, cyc);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hffffffff;
      total++;
      if (o !== e) $display("FAIL lap_tick: count_en at cycle %0d, required %0d", o, e);
      else passes++;
    end
    total++;
    if (obs_q.size() != 0) $display("FAIL lap_extra_tick: %0d extra, required 0", obs_q.size());
    else passes++;
  endtask

  task automatic test_clear();
    int c0;
    btn_stop = 1'b1;
    step(6);
    btn_stop = 1'b0;
    step(12);
    total++;
    if (state !== 2'b10) $display("FAIL clear_setup: state %b, required 10", state);
    else passes++;
    obs_q.delete();
    c0 = clr_cnt;
    btn_clear = 1'b1;
    btn_start = 1'b1;
    step(6);
    btn_clear = 1'b0;
    btn_start = 1'b0;
    step(2);
    total++;
    if (state !== 2'b00 || count_clr !== 1'b1 || count_en !== 1'b0)
      $display("FAIL clear_wins: state %b clr %b en %b, required 00 1 0", state, count_clr, count_en);
    else passes++;
    step(10);
    total++;
    if (clr_cnt != c0 + 1 || obs_q.size() != 0)
      $display("FAIL clear_single: clr pulses %0d en pulses %0d, required 1 0", clr_cnt - c0, obs_q.size());
    else passes++;
    btn_clear = 1'b1;
    step(6);
    btn_clear = 1'b0;
    step(2);
    total++;
    if (state !== 2'b00 || count_clr !== 1'b1)
      $display("FAIL clear_idle: state %b clr %b, required 00 1", state, count_clr);
    else passes++;
    step(3);
    total++;
    if (clr_cnt != c0 + 2 || both_cnt != 0)
      $display("FAIL clear_idle_count: clr pulses %0d overlaps %0d, required 2 0", clr_cnt - c0, both_cnt);
    else passes++;
  endtask

  task automatic test_max();
    btn_start = 1'b1;
    step(6);
    btn_start = 1'b0;
    step(2);
    total++;
    if (state !== 2'b01 || state1 !== 2'b01)
      $display("FAIL max_setup: state %b/%b, required 01/01", state, state1);
    else passes++;
    step(5);
    count_at_max = 1'b1;
    step(4);
    total++;
    if (state !== 2'b01) $display("FAIL max_before_tick: state %b, required 01", state);
    else passes++;
    step(1);
    total++;
    if (count_en !== 1'b0 || state !== 2'b10)
      $display("FAIL max_stop: en %b state %b, required 0 10", count_en, state);
    else passes++;
    total++;
    if (count_en1 !== 1'b1 || state1 !== 2'b01)
      $display("FAIL max_wrap: en %b state %b, required 1 01", count_en1, state1);
    else passes++;
    count_at_max = 1'b0;
    obs_q.delete();
  endtask

  task automatic test_reset_mid();
    btn_start = 1'b1;
    step(6);
    btn_start = 1'b0;
    step(6);
    btn_lap = 1'b1;
    step(6);
    btn_lap = 1'b0;
    step(6);
    total++;
    if (state !== 2'b11 || lap_active !== 1'b1)
      $display("FAIL mid_setup: state %b active %b, required 11 1", state, lap_active);
    else passes++;
    #2;
    RST = 1'b1;
    #1;
    total++;
    if ({state, count_en, count_clr, lap_latch, lap_active, running} !== 7'd0)
      $display("FAIL mid_reset: got %b, required 0000000",
               {state, count_en, count_clr, lap_latch, lap_active, running});
    else passes++;
    total++;
    if ({state1, count_en1, count_clr1, lap_latch1, lap_active1, running1} !== 7'd0)
      $display("FAIL mid_reset_wrap: got %b, required 0000000",
               {state1, count_en1, count_clr1, lap_latch1, lap_active1, running1});
    else passes++;
    step(2);
    RST = 1'b0;
    step(3);
    total++;
    if (state !== 2'b00) $display("FAIL post_reset: state %b, required 00", state);
    else passes++;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_start();
    test_glitch();
    test_pause();
    test_lap();
    test_clear();
    test_max();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
